// File: rtl/endec_job_scheduler_pkg.sv
// Shared state encoding and config-word layout for the endec job scheduler.
// The two macros size the generator polynomial field (one K-bit poly per output).
`ifndef MAX_CONSTRAINT_LENGTH
`define MAX_CONSTRAINT_LENGTH 9
`endif
`ifndef MAX_CODE_RATE
`define MAX_CODE_RATE 3
`endif

package endec_job_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCoreRst = 2'd1,
        StRun     = 2'd2,
        StResp    = 2'd3
    } state_e;

    localparam int unsigned GEN_POLY_W    = `MAX_CODE_RATE * `MAX_CONSTRAINT_LENGTH;
    localparam int unsigned CFG_W         = GEN_POLY_W + 1;
    localparam int unsigned CODE_RATE_BIT = GEN_POLY_W;

    function automatic logic cfg_code_rate(input logic [CFG_W-1:0] cfg);
        return cfg[CODE_RATE_BIT];
    endfunction

    function automatic logic [GEN_POLY_W-1:0] cfg_gen_poly(input logic [CFG_W-1:0] cfg);
        return cfg[GEN_POLY_W-1:0];
    endfunction

endpackage

// File: rtl/endec_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester set, searching upward from
// last_i+1 with wrap. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!found && req_i[j] && (j == (int'(last_i) + off) % int'(NUM_REQ))) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/endec_job_scheduler.sv
// Shares one endec core between NUM_REQ requesters: round-robin accept, config
// latch, core reset/enable sequencing, watchdog and tagged completion response.
module endec_job_scheduler
    import endec_job_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ID_W       = 3,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned TO_W       = 10
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*CFG_W-1:0] i_req_cfg,
    output logic [ID_W-1:0]          o_sel,
    output logic                     o_core_rst,
    output logic                     o_core_en,
    output logic                     o_code_rate,
    output logic [GEN_POLY_W-1:0]    o_gen_poly_flat,
    input  logic                     i_enc_done,
    input  logic                     i_dec_done,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic                     o_rsp_timeout,
    output logic                     o_busy,
    output logic [15:0]              o_job_cnt
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         last_q, last_d, sel_q, sel_d;
    logic                    code_rate_q, code_rate_d;
    logic [GEN_POLY_W-1:0]   gen_poly_q, gen_poly_d;
    logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]         wd_q, wd_d, wd_inc;
    logic                    enc_seen_q, enc_seen_d, dec_seen_q, dec_seen_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             job_cnt_q, job_cnt_d;

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic [CFG_W-1:0]        win_cfg;
    logic                    both_done, wd_expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i  (i_req_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    always_comb begin
        win_cfg = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) win_cfg = i_req_cfg[i*CFG_W +: CFG_W];
        end
    end

    // A done arriving this cycle counts, so completion can land on the timeout cycle.
    assign both_done = (enc_seen_q | i_enc_done) & (dec_seen_q | i_dec_done);
    assign wd_inc    = wd_q + TO_W'(1);
    assign wd_expire = (wd_inc == TO_W'(TIMEOUT));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (|gnt) state_d = StCoreRst;
            StCoreRst: if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = StRun;
            StRun:     if (both_done || wd_expire) state_d = StResp;
            StResp:    if (i_rsp_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready   = '0;
        o_core_rst    = 1'b0;
        o_core_en     = 1'b0;
        o_rsp_valid   = 1'b0;
        o_rsp_timeout = 1'b0;
        o_busy        = 1'b1;
        unique case (state_q)
            StIdle: begin
                o_req_ready = gnt;
                o_busy      = 1'b0;
            end
            StCoreRst: ;
            StRun: begin
                o_core_rst = 1'b1;
                o_core_en  = 1'b1;
            end
            StResp: begin
                o_core_rst    = 1'b1;
                o_rsp_valid   = 1'b1;
                o_rsp_timeout = timeout_q;
            end
            default: o_busy = 1'b0;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        sel_d       = sel_q;
        code_rate_d = code_rate_q;
        gen_poly_d  = gen_poly_q;
        rst_cnt_d   = rst_cnt_q;
        wd_d        = wd_q;
        enc_seen_d  = enc_seen_q;
        dec_seen_d  = dec_seen_q;
        timeout_d   = timeout_q;
        job_cnt_d   = job_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|gnt) begin
                    last_d      = gnt_idx;
                    sel_d       = gnt_idx;
                    code_rate_d = cfg_code_rate(win_cfg);
                    gen_poly_d  = cfg_gen_poly(win_cfg);
                    rst_cnt_d   = '0;
                end
            end
            StCoreRst: begin
                rst_cnt_d  = rst_cnt_q + RC_W'(1);
                wd_d       = '0;
                enc_seen_d = 1'b0;
                dec_seen_d = 1'b0;
            end
            StRun: begin
                wd_d       = wd_inc;
                enc_seen_d = enc_seen_q | i_enc_done;
                dec_seen_d = dec_seen_q | i_dec_done;
                timeout_d  = !both_done && wd_expire;
            end
            StResp: if (i_rsp_ready) job_cnt_d = job_cnt_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            last_q      <= ID_W'(NUM_REQ - 1);
            sel_q       <= '0;
            code_rate_q <= 1'b0;
            gen_poly_q  <= '0;
            rst_cnt_q   <= '0;
            wd_q        <= '0;
            enc_seen_q  <= 1'b0;
            dec_seen_q  <= 1'b0;
            timeout_q   <= 1'b0;
            job_cnt_q   <= '0;
        end else begin
            last_q      <= last_d;
            sel_q       <= sel_d;
            code_rate_q <= code_rate_d;
            gen_poly_q  <= gen_poly_d;
            rst_cnt_q   <= rst_cnt_d;
            wd_q        <= wd_d;
            enc_seen_q  <= enc_seen_d;
            dec_seen_q  <= dec_seen_d;
            timeout_q   <= timeout_d;
            job_cnt_q   <= job_cnt_d;
        end
    end

    assign o_sel           = sel_q;
    assign o_rsp_id        = sel_q;
    assign o_code_rate     = code_rate_q;
    assign o_gen_poly_flat = gen_poly_q;
    assign o_job_cnt       = job_cnt_q;

endmodule

// File: tb/tb_endec_job_scheduler.sv
// Directed self-checking bench for endec_job_scheduler (NUM_REQ=2, RST_CYCLES=2,
// TIMEOUT=1023). Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_endec_job_scheduler;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_req_valid = '0;
    logic [1:0]  o_req_ready;
    logic [55:0] i_req_cfg = '0;
    logic [2:0]  o_sel;
    logic        o_core_rst, o_core_en, o_code_rate;
    logic [26:0] o_gen_poly_flat;
    logic        i_enc_done = 1'b0, i_dec_done = 1'b0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [2:0]  o_rsp_id;
    logic        o_rsp_timeout, o_busy;
    logic [15:0] o_job_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    logic [56:0] out_view;
    assign out_view = {o_req_ready, o_core_rst, o_core_en, o_rsp_valid, o_rsp_timeout, o_busy,
                       o_sel, o_rsp_id, o_code_rate, o_gen_poly_flat, o_job_cnt};

    always #5 sys_clk = ~sys_clk;

    endec_job_scheduler #(
        .NUM_REQ    (2),
        .ID_W       (3),
        .RST_CYCLES (2),
        .TIMEOUT    (1023),
        .TO_W       (10)
    ) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_cfg       (i_req_cfg),
        .o_sel           (o_sel),
        .o_core_rst      (o_core_rst),
        .o_core_en       (o_core_en),
        .o_code_rate     (o_code_rate),
        .o_gen_poly_flat (o_gen_poly_flat),
        .i_enc_done      (i_enc_done),
        .i_dec_done      (i_dec_done),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_id        (o_rsp_id),
        .o_rsp_timeout   (o_rsp_timeout),
        .o_busy          (o_busy),
        .o_job_cnt       (o_job_cnt)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req_valid = 2'b00;
        repeat (2) tick();
        settle();
        total++;
        if (out_view !== 57'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", out_view, 57'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        i_req_cfg[27:0] = 28'h80001ED;
        i_req_valid = 2'b01;
        settle();
        total++;
        if (o_req_ready !== 2'b01) begin
            bad++; $display("FAIL single_ready got=%b want=01", o_req_ready);
        end
        tick();
        i_req_valid = 2'b00;
        i_req_cfg[27:0] = 28'h0000000;
        settle();
        total++;
        if ({o_req_ready, o_core_rst, o_core_en, o_busy, o_sel, o_code_rate, o_gen_poly_flat}
            !== {2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 27'h00001ED}) begin
            bad++;
            $display("FAIL single_corerst1 rdy=%b rst=%b en=%b busy=%b sel=%0d cr=%b gp=%h",
                     o_req_ready, o_core_rst, o_core_en, o_busy, o_sel, o_code_rate,
                     o_gen_poly_flat);
        end
        tick();
        settle();
        total++;
        if ({o_core_rst, o_core_en} !== 2'b00) begin
            bad++; $display("FAIL single_corerst2 got=%b want=00", {o_core_rst, o_core_en});
        end
        tick();
        settle();
        total++;
        if ({o_core_rst, o_core_en} !== 2'b11) begin
            bad++; $display("FAIL single_en_rise got=%b want=11", {o_core_rst, o_core_en});
        end
        repeat (40) tick();
        i_enc_done = 1'b1;
        settle();
        total++;
        if ({o_core_en, o_rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL single_enc_only got=%b want=10", {o_core_en, o_rsp_valid});
        end
        tick();
        i_enc_done = 1'b0;
        repeat (14) tick();
        i_dec_done = 1'b1;
        settle();
        total++;
        if ({o_core_en, o_rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL single_dec_cycle got=%b want=10", {o_core_en, o_rsp_valid});
        end
        tick();
        i_dec_done = 1'b0;
        settle();
        total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_timeout, o_core_en, o_core_rst, o_gen_poly_flat}
            !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 27'h00001ED}) begin
            bad++;
            $display("FAIL single_resp v=%b id=%0d to=%b en=%b rst=%b gp=%h", o_rsp_valid,
                     o_rsp_id, o_rsp_timeout, o_core_en, o_core_rst, o_gen_poly_flat);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        exp_cnt++;
        settle();
        total++;
        if ({o_rsp_valid, o_busy, o_core_rst, o_job_cnt} !== {3'b000, 16'(exp_cnt)}) begin
            bad++;
            $display("FAIL single_done v=%b busy=%b rst=%b cnt=%0d want cnt=%0d", o_rsp_valid,
                     o_busy, o_core_rst, o_job_cnt, exp_cnt);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [26:0] exp_gp;
        logic        exp_cr;
        tick();
        rst = 1'b1;
        settle();
        rst = 1'b0;
        exp_cnt = 0;
        i_req_cfg = {28'h8123456, 28'h0ABCDEF};
        i_req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_g  = (j % 2 == 0) ? 2'b01 : 2'b10;
            exp_gp = (j % 2 == 0) ? 27'h0ABCDEF : 27'h0123456;
            exp_cr = (j % 2 == 0) ? 1'b0 : 1'b1;
            settle();
            total++;
            if (o_req_ready !== exp_g) begin
                bad++; $display("FAIL rr_grant job=%0d got=%b want=%b", j, o_req_ready, exp_g);
            end
            tick();
            settle();
            total++;
            if ({o_sel, o_code_rate, o_gen_poly_flat} !== {3'(j % 2), exp_cr, exp_gp}) begin
                bad++;
                $display("FAIL rr_cfg job=%0d sel=%0d cr=%b gp=%h want sel=%0d cr=%b gp=%h", j,
                         o_sel, o_code_rate, o_gen_poly_flat, j % 2, exp_cr, exp_gp);
            end
            tick();
            tick();
            i_enc_done = 1'b1;
            i_dec_done = 1'b1;
            tick();
            i_enc_done = 1'b0;
            i_dec_done = 1'b0;
            settle();
            total++;
            if ({o_rsp_valid, o_rsp_id, o_req_ready} !== {1'b1, 3'(j % 2), 2'b00}) begin
                bad++;
                $display("FAIL rr_resp job=%0d v=%b id=%0d rdy=%b want id=%0d", j, o_rsp_valid,
                         o_rsp_id, o_req_ready, j % 2);
            end
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
            exp_cnt++;
        end
        i_req_valid = 2'b00;
        settle();
        total++;
        if (o_job_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL rr_jobcnt got=%0d want=%0d", o_job_cnt, exp_cnt);
        end
    endtask

    task automatic test_split_done();
        i_req_valid = 2'b01;
        settle();
        total++;
        if (o_req_ready !== 2'b01) begin
            bad++; $display("FAIL split_ready got=%b want=01", o_req_ready);
        end
        tick();
        i_req_valid = 2'b00;
        tick();
        tick();
        repeat (5) tick();
        i_dec_done = 1'b1;
        tick();
        i_dec_done = 1'b0;
        repeat (9) tick();
        i_enc_done = 1'b1;
        settle();
        total++;
        if ({o_core_en, o_rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL split_enc_cycle got=%b want=10", {o_core_en, o_rsp_valid});
        end
        tick();
        i_enc_done = 1'b0;
        settle();
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_core_en} !== 3'b100) begin
            bad++;
            $display("FAIL split_resp got=%b want=100", {o_rsp_valid, o_rsp_timeout, o_core_en});
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        exp_cnt++;
        i_req_valid = 2'b01;
        tick();
        i_req_valid = 2'b00;
        tick();
        tick();
        repeat (3) tick();
        i_enc_done = 1'b1;
        i_dec_done = 1'b1;
        settle();
        total++;
        if ({o_core_en, o_rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL simul_cycle got=%b want=10", {o_core_en, o_rsp_valid});
        end
        tick();
        i_enc_done = 1'b0;
        i_dec_done = 1'b0;
        settle();
        total++;
        if ({o_rsp_valid, o_rsp_timeout} !== 2'b10) begin
            bad++; $display("FAIL simul_resp got=%b want=10", {o_rsp_valid, o_rsp_timeout});
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        exp_cnt++;
        settle();
        total++;
        if (o_job_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL split_jobcnt got=%0d want=%0d", o_job_cnt, exp_cnt);
        end
    endtask

    task automatic test_watchdog();
        i_req_valid = 2'b01;
        tick();
        i_req_valid = 2'b00;
        tick();
        tick();
        settle();
        total++;
        if (o_core_en !== 1'b1) begin
            bad++; $display("FAIL wd_en_rise got=%b want=1", o_core_en);
        end
        repeat (1022) tick();
        settle();
        total++;
        if ({o_core_en, o_rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL wd_last_run got=%b want=10", {o_core_en, o_rsp_valid});
        end
        tick();
        i_req_valid = 2'b10;
        for (int k = 0; k < 20; k++) begin
            settle();
            total++;
            if ({o_rsp_valid, o_rsp_timeout, o_rsp_id, o_core_en, o_req_ready, o_core_rst}
                !== {1'b1, 1'b1, 3'd0, 1'b0, 2'b00, 1'b1}) begin
                bad++;
                $display("FAIL wd_backpressure k=%0d v=%b to=%b id=%0d en=%b rdy=%b rst=%b", k,
                         o_rsp_valid, o_rsp_timeout, o_rsp_id, o_core_en, o_req_ready,
                         o_core_rst);
            end
            tick();
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        exp_cnt++;
        settle();
        total++;
        if ({o_req_ready, o_job_cnt} !== {2'b10, 16'(exp_cnt)}) begin
            bad++;
            $display("FAIL wd_next_accept rdy=%b cnt=%0d want rdy=10 cnt=%0d", o_req_ready,
                     o_job_cnt, exp_cnt);
        end
        tick();
        i_req_valid = 2'b00;
        settle();
        total++;
        if (o_sel !== 3'd1) begin
            bad++; $display("FAIL wd_sel got=%0d want=1", o_sel);
        end
        tick();
        tick();
        repeat (100) tick();
        i_enc_done = 1'b1;
        tick();
        i_enc_done = 1'b0;
        repeat (921) tick();
        i_dec_done = 1'b1;
        settle();
        total++;
        if ({o_core_en, o_rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL wd_edge_cycle got=%b want=10", {o_core_en, o_rsp_valid});
        end
        tick();
        i_dec_done = 1'b0;
        settle();
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_id} !== {1'b1, 1'b0, 3'd1}) begin
            bad++;
            $display("FAIL wd_edge_resp v=%b to=%b id=%0d want 1 0 1", o_rsp_valid,
                     o_rsp_timeout, o_rsp_id);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        exp_cnt++;
        settle();
        total++;
        if (o_job_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL wd_jobcnt got=%0d want=%0d", o_job_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        i_req_valid = 2'b01;
        settle();
        total++;
        if (o_req_ready !== 2'b01) begin
            bad++; $display("FAIL midrst_ready got=%b want=01", o_req_ready);
        end
        tick();
        i_req_valid = 2'b00;
        tick();
        tick();
        settle();
        total++;
        if (o_core_en !== 1'b1) begin
            bad++; $display("FAIL midrst_en got=%b want=1", o_core_en);
        end
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_view !== 57'd0) begin
            bad++; $display("FAIL midrst_async got=%h want=%h", out_view, 57'd0);
        end
        tick();
        rst = 1'b0;
        i_req_valid = 2'b11;
        exp_cnt = 0;
        settle();
        total++;
        if ({o_req_ready, o_job_cnt} !== {2'b01, 16'(exp_cnt)}) begin
            bad++;
            $display("FAIL midrst_regrant rdy=%b cnt=%0d want rdy=01 cnt=0", o_req_ready,
                     o_job_cnt);
        end
        tick();
        i_req_valid = 2'b00;
        settle();
        total++;
        if ({o_sel, o_busy} !== {3'd0, 1'b1}) begin
            bad++; $display("FAIL midrst_sel sel=%0d busy=%b want 0 1", o_sel, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_split_done();
        test_watchdog();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
